// File: rtl/divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : divider_arbiter
// Purpose  : Round-robin front end that shares one divider between NREQ
//            requesters, with divide-by-zero bypass and hung-divider timeout.
// Revision : 1.0 - initial release
// ============================================================================
module divider_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 63
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [7*NREQ-1:0]    req_divisor,
   input  logic [8*NREQ-1:0]    req_dividend,
   output logic [NREQ-1:0]      done,
   output logic [7:0]           res_quotient,
   output logic [6:0]           res_remainder,
   output logic                 res_err,
   output logic                 busy,
   output logic [6:0]           div_divisor,
   output logic [7:0]           div_dividend,
   output logic                 div_start,
   input  logic [7:0]           div_quotient,
   input  logic [6:0]           div_remainder,
   input  logic                 div_valid
);

   localparam int C_IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int C_CNTW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_CLEAR = 3'd3,
      S_WAIT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [C_IDXW-1:0]  r_rr;
   logic [C_IDXW-1:0]  r_win;
   logic [C_IDXW-1:0]  w_pick;
   logic               w_found;
   logic [C_CNTW-1:0]  r_tcnt;
   logic               w_tmo;
   logic [6:0]         w_sel_divisor;
   logic [7:0]         w_sel_dividend;
   int                 w_idx;

   // Search upward from the round-robin pointer, wrapping to requester 0.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = int'(r_rr) + k;
         if (w_idx >= NREQ) w_idx = w_idx - NREQ;
         if (!w_found && 1'(req >> w_idx)) begin
            w_found = 1'b1;
            w_pick  = C_IDXW'(w_idx);
         end
      end
   end

   assign w_sel_divisor  = 7'(req_divisor  >> (7 * r_win));
   assign w_sel_dividend = 8'(req_dividend >> (8 * r_win));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_tmo  = (r_tcnt == C_CNTW'(TIMEOUT - 1));
      case (r_state)
         S_IDLE:  if (w_found) w_next = S_LOAD;
         S_LOAD:  w_next = (w_sel_divisor == 7'd0) ? S_DONE : S_START;
         S_START: w_next = S_CLEAR;
         // Timeout wins over a valid arriving in the same cycle.
         S_CLEAR: begin
            if (w_tmo)           w_next = S_DONE;
            else if (!div_valid) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (w_tmo || div_valid) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr          <= '0;
         r_win         <= '0;
         r_tcnt        <= '0;
         done          <= '0;
         res_quotient  <= '0;
         res_remainder <= '0;
         res_err       <= 1'b0;
         busy          <= 1'b0;
         div_start     <= 1'b0;
         div_divisor   <= '0;
         div_dividend  <= '0;
      end else begin
         busy      <= (w_next != S_IDLE);
         div_start <= (w_next == S_START);
         done      <= (w_next == S_DONE) ? (NREQ'(1) << r_win) : '0;

         if (r_state == S_IDLE && w_found) r_win <= w_pick;

         if (r_state == S_LOAD) begin
            div_divisor  <= w_sel_divisor;
            div_dividend <= w_sel_dividend;
         end

         if (r_state == S_START)
            r_tcnt <= '0;
         else if (r_state == S_CLEAR || r_state == S_WAIT)
            r_tcnt <= r_tcnt + 1'b1;

         if (r_state == S_LOAD && w_sel_divisor == 7'd0) begin
            res_quotient  <= 8'hFF;
            res_remainder <= w_sel_dividend[6:0];
            res_err       <= 1'b1;
         end else if ((r_state == S_CLEAR || r_state == S_WAIT) && w_tmo) begin
            res_quotient  <= '0;
            res_remainder <= '0;
            res_err       <= 1'b1;
         end else if (r_state == S_WAIT && div_valid) begin
            res_quotient  <= div_quotient;
            res_remainder <= div_remainder;
            res_err       <= 1'b0;
         end

         if (r_state == S_DONE)
            r_rr <= (r_win == C_IDXW'(NREQ - 1)) ? '0 : r_win + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_arbiter
// Purpose  : Directed self-checking bench for divider_arbiter with a divider
//            stub and a transaction-level round-robin/result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_arbiter;

   localparam int NREQ    = 2;
   localparam int TIMEOUT = 63;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [13:0] req_divisor;
   logic [15:0] req_dividend;
   logic [1:0]  done;
   logic [7:0]  res_quotient;
   logic [6:0]  res_remainder;
   logic        res_err;
   logic        busy;
   logic [6:0]  div_divisor;
   logic [7:0]  div_dividend;
   logic        div_start;

   logic [7:0]  opa [NREQ];
   logic [6:0]  opb [NREQ];

   // divider stub state
   int          lat;
   int          stale;
   bit          hang;
   logic        dv;
   logic [7:0]  dq;
   logic [6:0]  dr;
   logic [7:0]  sa;
   logic [6:0]  sb;
   int          dcnt;
   int          sleft;
   bit          dbusy;

   int n_chk  = 0;
   int n_fail = 0;

   assign req_divisor  = {opb[1], opb[0]};
   assign req_dividend = {opa[1], opa[0]};

   always #5 clk = ~clk;

   divider_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req(req),
      .req_divisor(req_divisor), .req_dividend(req_dividend),
      .done(done), .res_quotient(res_quotient), .res_remainder(res_remainder),
      .res_err(res_err), .busy(busy),
      .div_divisor(div_divisor), .div_dividend(div_dividend), .div_start(div_start),
      .div_quotient(dq), .div_remainder(dr), .div_valid(dv)
   );

   // Divider stub: valid stays high after a result; an optional stale phase
   // keeps the old valid up for a few cycles after start.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         dv <= 1'b0; dq <= '0; dr <= '0; dbusy <= 1'b0; dcnt <= 0; sleft <= 0;
      end else if (div_start) begin
         sa <= div_dividend; sb <= div_divisor; dbusy <= 1'b1;
         dcnt <= lat; sleft <= stale;
         if (stale == 0) dv <= 1'b0;
      end else if (dbusy) begin
         if (sleft > 0) begin
            sleft <= sleft - 1;
            if (sleft == 1) dv <= 1'b0;
         end else if (!hang) begin
            if (dcnt > 1) dcnt <= dcnt - 1;
            else begin
               dv    <= 1'b1;
               dq    <= sa / {1'b0, sb};
               dr    <= 7'(sa % {1'b0, sb});
               dbusy <= 1'b0;
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int model_pick(input logic [NREQ-1:0] r, input int rr);
      logic [NREQ-1:0] t;
      for (int k = 0; k < NREQ; k++) begin
         t = r >> ((rr + k) % NREQ);
         if (t[0]) return (rr + k) % NREQ;
      end
      return -1;
   endfunction

   // Model: round-robin pointer plus arithmetic expectation of each result.
   int m_rr = 0;
   int done_cnt = 0;
   int start_cnt = 0;
   int last_win, last_q, last_r, last_e;
   bit prev_start = 1'b0;
   bit prev_done  = 1'b0;
   int mw, eq, er, ee;

   always @(negedge clk) begin
      if (reset) begin
         m_rr = 0; prev_start = 1'b0; prev_done = 1'b0;
      end else begin
         if (div_start) begin
            start_cnt++;
            mw = model_pick(req, m_rr);
            chk("start_pulse_width", int'(prev_start), 0);
            if (mw >= 0) begin
               chk("div_divisor", int'(div_divisor), int'(opb[mw]));
               chk("div_dividend", int'(div_dividend), int'(opa[mw]));
            end else chk("start_without_req", 1, 0);
         end
         prev_start = div_start;
         if (done != 2'b00) begin
            mw = model_pick(req, m_rr);
            if (mw < 0) begin
               chk("done_without_req", int'(done), 0);
            end else begin
               if (opb[mw] == 7'd0) begin
                  eq = 255; er = int'(opa[mw] & 8'h7F); ee = 1;
               end else if (hang) begin
                  eq = 0; er = 0; ee = 1;
               end else begin
                  eq = int'(opa[mw]) / int'(opb[mw]);
                  er = int'(opa[mw]) % int'(opb[mw]);
                  ee = 0;
               end
               chk("done_onehot", int'(done), 1 << mw);
               chk("res_quotient", int'(res_quotient), eq);
               chk("res_remainder", int'(res_remainder), er);
               chk("res_err", int'(res_err), ee);
               chk("busy_in_done", int'(busy), 1);
               chk("done_one_cycle", int'(prev_done), 0);
               m_rr = (mw + 1) % NREQ;
            end
            last_win = (done == 2'b01) ? 0 : (done == 2'b10) ? 1 : -1;
            last_q = int'(res_quotient);
            last_r = int'(res_remainder);
            last_e = int'(res_err);
            done_cnt++;
         end
         prev_done = (done != 2'b00);
      end
   end

   task automatic wait_done(input int maxc, output int cyc);
      int prev;
      prev = done_cnt;
      cyc  = 0;
      while (done_cnt == prev && cyc < maxc) begin
         @(negedge clk); #1;
         cyc++;
      end
      if (done_cnt == prev) chk("done_wait_expired", 0, 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_quotient"}, int'(res_quotient), 0);
      chk({tag, "_remainder"}, int'(res_remainder), 0);
      chk({tag, "_err"}, int'(res_err), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_start"}, int'(div_start), 0);
      chk({tag, "_divisor"}, int'(div_divisor), 0);
      chk({tag, "_dividend"}, int'(div_dividend), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int s0, d0;
      int wins [4];
      req = 2'b00; reset = 1'b0; hang = 1'b0; stale = 0; lat = 3;
      opa[0] = '0; opa[1] = '0; opb[0] = '0; opb[1] = '0;
      #2 reset = 1'b1;
      #1 chk_all_zero("reset");
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;

      // contention: both requesters, 200/9
      opa[0] = 8'd200; opb[0] = 7'd9; opa[1] = 8'd200; opb[1] = 7'd9;
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_done(40, cyc);
         wins[i] = last_win;
         chk("cont_quotient", last_q, 22);
         chk("cont_remainder", last_r, 2);
         chk("cont_err", last_e, 0);
      end
      req = 2'b00;
      chk("cont_win0", wins[0], 0);
      chk("cont_win1", wins[1], 1);
      chk("cont_win2", wins[2], 0);
      chk("cont_win3", wins[3], 1);

      // single request 100/7
      repeat (2) @(negedge clk);
      #1 chk("idle_busy", int'(busy), 0);
      s0 = start_cnt; d0 = done_cnt;
      opa[0] = 8'd100; opb[0] = 7'd7; req = 2'b01;
      wait_done(40, cyc);
      req = 2'b00;
      chk("single_win", last_win, 0);
      chk("single_quotient", last_q, 14);
      chk("single_remainder", last_r, 2);
      chk("single_err", last_e, 0);
      repeat (3) @(negedge clk);
      #1;
      chk("single_start_count", start_cnt - s0, 1);
      chk("single_done_count", done_cnt - d0, 1);

      // divide by zero from requester 1
      s0 = start_cnt;
      opa[1] = 8'hA5; opb[1] = 7'd0; req = 2'b10;
      wait_done(10, cyc);
      req = 2'b00;
      chk("div0_win", last_win, 1);
      chk("div0_quotient", last_q, 255);
      chk("div0_remainder", last_r, 37);
      chk("div0_err", last_e, 1);
      chk("div0_latency_le4", int'(cyc <= 4), 1);
      chk("div0_no_start", start_cnt - s0, 0);

      // hung divider -> timeout
      repeat (2) @(negedge clk);
      #1 hang = 1'b1;
      opa[0] = 8'd77; opb[0] = 7'd5; req = 2'b01;
      wait_done(200, cyc);
      req = 2'b00;
      chk("tmo_win", last_win, 0);
      chk("tmo_quotient", last_q, 0);
      chk("tmo_remainder", last_r, 0);
      chk("tmo_err", last_e, 1);
      chk("tmo_latency", cyc, TIMEOUT + 3);

      // normal op after timeout, leaves valid high for the next test
      repeat (2) @(negedge clk);
      #1 hang = 1'b0;
      opa[1] = 8'd50; opb[1] = 7'd5; req = 2'b10;
      wait_done(40, cyc);
      req = 2'b00;
      chk("post_tmo_win", last_win, 1);
      chk("post_tmo_quotient", last_q, 10);
      chk("post_tmo_err", last_e, 0);

      // stale valid held through START
      repeat (2) @(negedge clk);
      #1 stale = 4;
      opa[0] = 8'd100; opb[0] = 7'd7; req = 2'b01;
      wait_done(60, cyc);
      req = 2'b00;
      stale = 0;
      chk("stale_quotient", last_q, 14);
      chk("stale_remainder", last_r, 2);
      chk("stale_err", last_e, 0);

      // reset while waiting on a hung op
      repeat (2) @(negedge clk);
      #1 hang = 1'b1;
      opa[1] = 8'd9; opb[1] = 7'd3; req = 2'b10;
      repeat (8) @(negedge clk);
      #1 d0 = done_cnt;
      chk("midop_busy", int'(busy), 1);
      reset = 1'b1;
      #1 chk_all_zero("async_reset");
      repeat (2) @(negedge clk);
      #1 reset = 1'b0; hang = 1'b0;
      chk("midop_no_done", done_cnt - d0, 0);
      opa[0] = 8'd60; opb[0] = 7'd7; req = 2'b11;
      wait_done(40, cyc);
      req = 2'b10;
      chk("rr_restart_win", last_win, 0);
      chk("rr_restart_quotient", last_q, 8);
      chk("rr_restart_remainder", last_r, 4);
      wait_done(40, cyc);
      req = 2'b00;
      chk("fresh_win", last_win, 1);
      chk("fresh_quotient", last_q, 3);
      chk("fresh_remainder", last_r, 0);

      repeat (4) @(negedge clk);
      #1 chk("total_done", done_cnt, 11);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
